uart_mem_loader: RTL and testbench
==================================

// Module: uart_mem_loader
// PURPOSE
// - Serial-side initiator for the j1_32 system: turns byte commands from the UART receive path into memory write/read cycles and returns responses on the UART transmit path.
// - The UART is normally a responder to CPU bus cycles. This block is the opposite end: the host drives memory over the serial link.
// - Holds the CPU in reset (cpu_hold) until the host sends GO, which gives boot-loading and peek/poke debug.
// PARAMETERS
// - ADDR_W      16          memory word-address width; address is sent as 2 bytes, MSB first
// - DATA_W      32          memory word width; fixed at 4 bytes, MSB first
// - RD_LAT      1           cycles from mem_re pulse to valid mem_rdata (1..3)
// - TIMEOUT_CYC 1_000_000   maximum idle cycles between bytes of one command
// PORTS
// - clk         in   1        system clock (100 MHz)
// - rst         in   1        synchronous, active-high reset
// - rx_data     in   8        received byte
// - rx_valid    in   1        1-cycle strobe; rx_data is valid in that cycle
// - tx_data     out  8        byte to transmit
// - tx_valid    out  1        transmit request
// - tx_ready    in   1        UART accepts tx_data when tx_valid & tx_ready
// - mem_addr    out  ADDR_W   memory word address
// - mem_wdata   out  DATA_W   memory write data
// - mem_we      out  1        1-cycle write pulse
// - mem_re      out  1        1-cycle read pulse
// - mem_rdata   in   DATA_W   read data, valid RD_LAT cycles after mem_re
// - cpu_hold    out  1        holds the CPU in reset while 1
// - rx_overrun  out  1        sticky flag: a byte arrived while not accepting
// BEHAVIOUR
// - Reset values: tx_valid=0, tx_data=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, cpu_hold=1, rx_overrun=0, state=IDLE.
// - Commands:
//   - 'W'(0x57) AH AL D3 D2 D1 D0 -> write, then reply 'K'(0x4B)
//   - 'R'(0x52) AH AL -> read, then reply D3..D0
//   - 'G'(0x47) -> cpu_hold<=0, then reply 'K'
//   - 'H'(0x48) -> cpu_hold<=1, then reply 'K'
//   - any other byte in IDLE -> reply '?'(0x3F)
// - FSM states: IDLE, ADDR_H, ADDR_L, DATA, MEM_WR, MEM_RD, RD_WAIT, RESP.
//   - IDLE: on 'W' or 'R', latch the opcode and go to ADDR_H.
//   - ADDR_H -> ADDR_L. After ADDR_L: 'W' goes to DATA, 'R' goes to MEM_RD.
//   - DATA: shift 4 bytes into mem_wdata, then go to MEM_WR.
//   - MEM_WR: mem_we=1 for exactly one cycle, then RESP.
//   - MEM_RD: mem_re=1 for exactly one cycle, then RD_WAIT.
//   - RD_WAIT: capture mem_rdata exactly RD_LAT cycles after mem_re, then RESP.
//   - RESP: send 1 byte ('K'/'?') or 4 bytes (read data, MSB first), then IDLE.
// - mem_addr and mem_wdata stay stable from their last byte until the next command overwrites them.
// - TX handshake: tx_data and tx_valid are held stable until the tx_valid & tx_ready cycle. The next byte may be presented the following cycle, never the same cycle.
// - rx_valid is consumed only in IDLE/ADDR_H/ADDR_L/DATA. A byte in any other state is dropped and sets rx_overrun, which clears only on rst.
// - Timeout: a counter reloads on every accepted byte while in ADDR_H/ADDR_L/DATA.
//   - Reaching TIMEOUT_CYC-1 with no byte: return to IDLE, no reply, no memory cycle.
//   - A byte arriving in the same cycle as the timeout wins; the counter reloads.
// - Address is 2 bytes regardless of ADDR_W: upper bits truncate, missing bits zero-extend.
// - rst mid-command (any state): abort immediately, no partial mem_we, outputs return to reset values, cpu_hold returns to 1.
// STRUCTURE
// - Opcode and response byte constants, plus the state encoding, go in define.v as `define entries (next to `UartDataWidth).
// - Sub-module byte_timeout: reloadable down-counter with a load/expired interface, parameterised by TIMEOUT_CYC.
// - Data shift register, RD_LAT delay line and FSM stay in this module.
// TESTING
// - Reset, then 'W' 00 10 DE AD BE EF -> one mem_we pulse with mem_addr=0x0010, mem_wdata=0xDEADBEEF; tx 0x4B.
// - 'R' 00 10 with mem_rdata=0x12345678, RD_LAT=1 -> one mem_re pulse; tx 0x12,0x34,0x56,0x78 in order.
// - tx_ready low for 20 cycles during a read reply -> tx_data/tx_valid stable throughout; no byte lost or repeated.
// - 'W' 00 10 AA, then silence (TIMEOUT_CYC=100) -> back to IDLE; no mem_we, no tx. A following 'R' works normally.
// - 0x00 in IDLE -> tx 0x3F. 'G' -> cpu_hold falls, tx 0x4B. Byte sent during RESP -> rx_overrun=1.
// - rst asserted after 'W' 00 10 DE -> no mem_we, cpu_hold=1, rx_overrun=0, FSM in IDLE.

Source files
------------

// File: rtl/uart_mem_loader_pkg.sv
// Shared constants and state encoding for the UART memory loader.
package uart_mem_loader_pkg;

  // Host command opcodes and reply bytes
  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] OP_GO    = 8'h47;  // 'G'
  localparam logic [7:0] OP_HALT  = 8'h48;  // 'H'
  localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA, S_MEM_WR, S_MEM_RD, S_RD_WAIT, S_RESP
  } state_t;

  // States in which an incoming byte is consumed; anywhere else it is an overrun
  function automatic logic accepts_rx(state_t s);
    return (s == S_IDLE) || (s == S_ADDR_H) || (s == S_ADDR_L) || (s == S_DATA);
  endfunction

  // States in which a stalled host aborts the command
  function automatic logic timeout_armed(state_t s);
    return (s == S_ADDR_H) || (s == S_ADDR_L) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/uart_mem_loader_timeout.sv
// Reloadable down-counter: expired rises after TIMEOUT_CYC-1 cycles without a load.
module byte_timeout #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Reload on every accepted byte, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst || load)     cnt <= RELOAD;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/uart_mem_loader.sv
// Host-driven memory initiator: UART byte commands become memory cycles and replies.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              rx_overrun
);
  localparam int NBYTES = DATA_W / 8;

  state_t            state;
  logic              is_read;
  logic [7:0]        addr_hi;
  logic [1:0]        byte_cnt;
  logic [DATA_W-1:0] resp_buf;   // reply bytes, next one to send in the top byte
  logic [2:0]        resp_left;
  logic [RD_LAT-1:0] re_pipe;    // mem_re delayed; top bit marks valid mem_rdata
  logic              rx_take;
  logic              tmo_expired;

  assign rx_take = rx_valid && accepts_rx(state);

  byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (rx_take),
    .expired (tmo_expired)
  );

  // Read-latency delay line following each mem_re pulse
  always_ff @(posedge clk) begin
    if (rst) re_pipe <= '0;
    else     re_pipe <= (re_pipe << 1) | RD_LAT'(mem_re);
  end

  // Command FSM with registered memory, transmit and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      is_read    <= 1'b0;
      addr_hi    <= '0;
      byte_cnt   <= '0;
      resp_buf   <= '0;
      resp_left  <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      cpu_hold   <= 1'b1;
      rx_overrun <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      if (rx_valid && !accepts_rx(state)) rx_overrun <= 1'b1;

      case (state)
        S_IDLE: if (rx_valid) begin
          resp_buf  <= {RSP_OK, {(DATA_W-8){1'b0}}};
          resp_left <= 3'd1;
          state     <= S_RESP;
          case (rx_data)
            OP_WRITE: begin is_read <= 1'b0; state <= S_ADDR_H; end
            OP_READ:  begin is_read <= 1'b1; state <= S_ADDR_H; end
            OP_GO:    cpu_hold <= 1'b0;
            OP_HALT:  cpu_hold <= 1'b1;
            default:  resp_buf <= {RSP_ERR, {(DATA_W-8){1'b0}}};
          endcase
        end

        // A byte in the same cycle as the timeout takes priority
        S_ADDR_H: begin
          if (rx_valid) begin
            addr_hi <= rx_data;
            state   <= S_ADDR_L;
          end else if (tmo_expired) state <= S_IDLE;
        end

        S_ADDR_L: begin
          if (rx_valid) begin
            mem_addr <= ADDR_W'({addr_hi, rx_data});
            byte_cnt <= '0;
            if (is_read) begin
              mem_re <= 1'b1;
              state  <= S_MEM_RD;
            end else state <= S_DATA;
          end else if (tmo_expired) state <= S_IDLE;
        end

        S_DATA: begin
          if (rx_valid) begin
            mem_wdata <= {mem_wdata[DATA_W-9:0], rx_data};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we <= 1'b1;
              state  <= S_MEM_WR;
            end
          end else if (tmo_expired) state <= S_IDLE;
        end

        S_MEM_WR: begin
          resp_buf  <= {RSP_OK, {(DATA_W-8){1'b0}}};
          resp_left <= 3'd1;
          state     <= S_RESP;
        end

        S_MEM_RD: state <= S_RD_WAIT;

        S_RD_WAIT: if (re_pipe[RD_LAT-1]) begin
          resp_buf  <= mem_rdata;
          resp_left <= 3'(NBYTES);
          state     <= S_RESP;
        end

        // Present one byte, hold it until accepted, then drop valid for a cycle
        S_RESP: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= resp_buf[DATA_W-1 -: 8];
          end else if (tx_ready) begin
            tx_valid  <= 1'b0;
            resp_buf  <= resp_buf << 8;
            resp_left <= resp_left - 3'd1;
            if (resp_left == 3'd1) state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed plus randomized bench for uart_mem_loader against a command-level model.
module tb_uart_mem_loader;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 1;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_hold;
  logic              rx_overrun;

  always #5 clk = ~clk;

  uart_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .rx_overrun(rx_overrun)
  );

  // Environment memory: data valid only in the cycle RD_LAT(=1) after mem_re, noise otherwise
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_re ? mem[mem_addr] : $urandom();
  end

  // Reference model: what the host expects memory to hold
  logic [31:0] ref_mem [0:65535];
  logic [15:0] written[$];

  int checks = 0;
  int failures = 0;
  logic [7:0]  tx_q[$];
  int          we_cnt = 0;
  int          re_cnt = 0;
  logic [15:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [15:0] last_raddr = '0;
  logic        pend = 1'b0;
  logic [7:0]  pend_data = '0;
  int          stall = 0;
  bit          rnd_ready = 1'b0;

  // Bus monitor and tx hold-stability check
  always @(negedge clk) begin
    if (pend && !rst) begin
      checks++;
      assert (tx_valid === 1'b1 && tx_data === pend_data) else begin
        failures++;
        $error("FAIL tx_hold observed valid=%0b data=%02h expected valid=1 data=%02h",
               tx_valid, tx_data, pend_data);
      end
    end
    pend      = tx_valid && !tx_ready && !rst;
    pend_data = tx_data;
    if (tx_valid && tx_ready && !rst) tx_q.push_back(tx_data);
    if (mem_we) begin we_cnt++; last_waddr = mem_addr; last_wdata = mem_wdata; end
    if (mem_re) begin re_cnt++; last_raddr = mem_addr; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall > 0) begin tx_ready = 1'b0; stall--; end
    else tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom());
    repeat (gap) tick();
  endtask

  // Send a command and compare the reply stream; gap<0 picks short random gaps
  task automatic run_cmd(input string tag, input logic [7:0] cmd[$], input logic [7:0] exp[$],
                         input int gap, input int stall_after);
    int n;
    tx_q.delete();
    foreach (cmd[i]) send_byte(cmd[i], (gap < 0) ? $urandom_range(0, 3) : gap);
    stall = stall_after;
    n = 0;
    while (tx_q.size() < exp.size() && n < 2000) begin tick(); n++; end
    repeat (10) tick();
    chk({tag, " tx_count"}, 32'(tx_q.size()), 32'(exp.size()));
    foreach (exp[i])
      if (i < tx_q.size()) chk($sformatf("%s tx_byte%0d", tag, i), 32'(tx_q[i]), 32'(exp[i]));
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input int gap);
    logic [7:0] c[$];
    logic [7:0] e[$];
    int we0;
    we0 = we_cnt;
    ref_mem[a] = d;
    written.push_back(a);
    c.push_back(8'h57); c.push_back(a[15:8]); c.push_back(a[7:0]);
    c.push_back(d[31:24]); c.push_back(d[23:16]); c.push_back(d[15:8]); c.push_back(d[7:0]);
    e.push_back(8'h4B);
    run_cmd("write", c, e, gap, 0);
    chk("write we_pulses", 32'(we_cnt - we0), 32'd1);
    chk("write addr", 32'(last_waddr), 32'(a));
    chk("write data", last_wdata, d);
  endtask

  task automatic do_read(input logic [15:0] a, input int stall_after);
    logic [7:0] c[$];
    logic [7:0] e[$];
    logic [31:0] d;
    int re0;
    re0 = re_cnt;
    d = ref_mem[a];
    c.push_back(8'h52); c.push_back(a[15:8]); c.push_back(a[7:0]);
    e.push_back(d[31:24]); e.push_back(d[23:16]); e.push_back(d[15:8]); e.push_back(d[7:0]);
    run_cmd("read", c, e, -1, stall_after);
    chk("read re_pulses", 32'(re_cnt - re0), 32'd1);
    chk("read addr", 32'(last_raddr), 32'(a));
  endtask

  task automatic do_single(input string tag, input logic [7:0] b, input logic [7:0] rsp);
    logic [7:0] c[$];
    logic [7:0] e[$];
    c.push_back(b);
    e.push_back(rsp);
    run_cmd(tag, c, e, 0, 0);
  endtask

  initial begin
    int we0;
    int re0;
    logic [7:0] b;
    logic [15:0] a;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst tx_valid", 32'(tx_valid), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_re", 32'(mem_re), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst rx_overrun", 32'(rx_overrun), 32'd0);
    rst = 1'b0;
    tick();

    // Directed write/read, including a 20-cycle tx_ready stall in the reply
    do_write(16'h0010, 32'hDEADBEEF, 0);
    do_write(16'h0020, 32'h12345678, -1);
    do_read(16'h0020, 20);
    do_read(16'h0010, 0);

    // Host pausing just short of the timeout still completes the command
    do_write(16'h0030, 32'hCAFEF00D, TMO - 10);
    do_read(16'h0030, 0);

    // Random traffic with random tx backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (($urandom_range(0, 1) == 0) || (written.size() == 0)) begin
        a = 16'($urandom());
        do_write(a, $urandom(), -1);
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        do_read(a, 0);
      end
    end
    rnd_ready = 1'b0;

    // Incomplete write then silence: no memory cycle, no reply
    we0 = we_cnt;
    tx_q.delete();
    send_byte(8'h57, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'hAA, 0);
    repeat (TMO + 50) tick();
    chk("timeout we_pulses", 32'(we_cnt - we0), 32'd0);
    chk("timeout tx_count", 32'(tx_q.size()), 32'd0);
    do_read(16'h0010, 0);

    // Unknown opcodes
    do_single("unknown00", 8'h00, 8'h3F);
    do
      b = 8'($urandom());
    while (b == 8'h57 || b == 8'h52 || b == 8'h47 || b == 8'h48);
    do_single("unknown_rand", b, 8'h3F);
    chk("overrun still clear", 32'(rx_overrun), 32'd0);

    // Go / halt
    do_single("go", 8'h47, 8'h4B);
    chk("go cpu_hold", 32'(cpu_hold), 32'd0);
    do_single("halt", 8'h48, 8'h4B);
    chk("halt cpu_hold", 32'(cpu_hold), 32'd1);

    // Byte arriving during a stalled reply is dropped and flagged
    re0 = re_cnt;
    tx_q.delete();
    stall = 40;
    send_byte(8'h52, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
    repeat (6) tick();
    send_byte(8'h55, 0);
    for (int n = 0; n < 500 && tx_q.size() < 4; n++) tick();
    repeat (10) tick();
    chk("overrun flag", 32'(rx_overrun), 32'd1);
    chk("overrun tx_count", 32'(tx_q.size()), 32'd4);
    if (tx_q.size() == 4) chk("overrun rdata", {tx_q[0], tx_q[1], tx_q[2], tx_q[3]}, ref_mem[16'h0010]);
    chk("overrun re_pulses", 32'(re_cnt - re0), 32'd1);

    // Reset in the middle of a write aborts it and restores reset values
    do_single("go2", 8'h47, 8'h4B);
    we0 = we_cnt;
    send_byte(8'h57, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'hDE, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("midrst we_pulses", 32'(we_cnt - we0), 32'd0);
    chk("midrst cpu_hold", 32'(cpu_hold), 32'd1);
    chk("midrst rx_overrun", 32'(rx_overrun), 32'd0);
    chk("midrst tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst mem_addr", 32'(mem_addr), 32'd0);
    do_read(16'h0010, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
